// File: rtl/hall_sensor_emulator_if.sv
// rtl/hall_sensor_emulator_if.sv - control and Hall-output bundle of the Hall sensor emulator
interface hall_sensor_emulator_if;
    logic        enable;
    logic        dir;
    logic [12:0] rpm_set;
    logic        hall_a;
    logic        hall_b;
    logic        hall_c;
    logic [2:0]  step_idx;
    logic [12:0] rpm_cur;
    logic        step_tick;
    logic        rev_tick;
    logic        dir_cur;

    modport master (
        output enable, dir, rpm_set,
        input  hall_a, hall_b, hall_c, step_idx, rpm_cur, step_tick, rev_tick, dir_cur
    );

    modport slave (
        input  enable, dir, rpm_set,
        output hall_a, hall_b, hall_c, step_idx, rpm_cur, step_tick, rev_tick, dir_cur
    );
endinterface

// File: rtl/hall_sensor_emulator.sv
// rtl/hall_sensor_emulator.sv - 3-phase Hall waveform source with phase accumulator and speed slew limiter
module hall_sensor_emulator #(
    parameter int STEP_THRESH   = 62500000,
    parameter int STEPS_PER_REV = 48,
    parameter int RPM_MAX       = 5000,
    parameter int RAMP_DIV      = 50000,
    parameter int RAMP_INC      = 10
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    hall_sensor_emulator_if.slave   bus
);
    localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int REV_W   = (STEPS_PER_REV > 1) ? $clog2(STEPS_PER_REV) : 1;
    localparam logic [27:0]        THRESH     = 28'(STEP_THRESH);
    localparam logic [12:0]        RPM_CEIL   = 13'(RPM_MAX);
    localparam logic [13:0]        INC        = 14'(RAMP_INC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
    localparam logic [REV_W-1:0]   REV_LAST   = REV_W'(STEPS_PER_REV - 1);

    logic [26:0]        acc;
    logic [12:0]        rpm_cur;
    logic [2:0]         step_idx;
    logic [2:0]         hall;
    logic               step_tick;
    logic               rev_tick;
    logic [REV_W-1:0]   rev_cnt;
    logic [PRESC_W-1:0] presc;
    logic               dir_cur;

    logic        ramp_tick;
    logic [12:0] tgt;
    logic [13:0] diff;
    logic [12:0] rpm_nxt;
    logic [27:0] sum;
    logic        advance;
    logic [26:0] acc_nxt;
    logic [2:0]  idx_nxt;

    function automatic logic [2:0] hall_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    hall_pattern = 3'b101;
            3'd1:    hall_pattern = 3'b100;
            3'd2:    hall_pattern = 3'b110;
            3'd3:    hall_pattern = 3'b010;
            3'd4:    hall_pattern = 3'b011;
            3'd5:    hall_pattern = 3'b001;
            default: hall_pattern = 3'b101;
        endcase
    endfunction

    // A pending reversal forces the target to zero so the motor stops before turning around.
    always_comb begin
        tgt = '0;
        if (bus.enable && (bus.dir == dir_cur))
            tgt = (bus.rpm_set > RPM_CEIL) ? RPM_CEIL : bus.rpm_set;
    end

    assign ramp_tick = (presc == PRESC_LAST);

    always_comb begin
        rpm_nxt = rpm_cur;
        diff    = '0;
        if (ramp_tick) begin
            if (tgt > rpm_cur) begin
                diff    = {1'b0, tgt} - {1'b0, rpm_cur};
                rpm_nxt = (diff > INC) ? (rpm_cur + INC[12:0]) : tgt;
            end else if (tgt < rpm_cur) begin
                diff    = {1'b0, rpm_cur} - {1'b0, tgt};
                rpm_nxt = (diff > INC) ? (rpm_cur - INC[12:0]) : tgt;
            end
        end
    end

    // acc stays below THRESH, so rpm_cur==0 can never produce an advance.
    assign sum     = {1'b0, acc} + {15'b0, rpm_cur};
    assign advance = (sum >= THRESH);
    assign acc_nxt = advance ? 27'(sum - THRESH) : sum[26:0];

    always_comb begin
        idx_nxt = step_idx;
        if (dir_cur == 1'b0)
            idx_nxt = (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;
        else
            idx_nxt = (step_idx == 3'd0) ? 3'd5 : step_idx - 3'd1;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            rpm_cur   <= '0;
            step_idx  <= 3'd0;
            hall      <= 3'b101;
            step_tick <= 1'b0;
            rev_tick  <= 1'b0;
            rev_cnt   <= '0;
            presc     <= '0;
            dir_cur   <= 1'b0;
        end else begin
            presc     <= ramp_tick ? '0 : presc + PRESC_W'(1);
            rpm_cur   <= rpm_nxt;
            acc       <= acc_nxt;
            step_tick <= advance;
            rev_tick  <= advance && (rev_cnt == REV_LAST);
            if ((rpm_cur == 13'd0) && (bus.dir != dir_cur))
                dir_cur <= bus.dir;
            if (advance) begin
                step_idx <= idx_nxt;
                hall     <= hall_pattern(idx_nxt);
                rev_cnt  <= (rev_cnt == REV_LAST) ? '0 : rev_cnt + REV_W'(1);
            end
        end
    end

    assign bus.hall_a    = hall[2];
    assign bus.hall_b    = hall[1];
    assign bus.hall_c    = hall[0];
    assign bus.step_idx  = step_idx;
    assign bus.rpm_cur   = rpm_cur;
    assign bus.step_tick = step_tick;
    assign bus.rev_tick  = rev_tick;
    assign bus.dir_cur   = dir_cur;
endmodule
